// File: rtl/i2s_rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// i2s_rx_ctrl_pkg
// Shared types and helpers for the I2S receive controller:
//   - state_e          : controller FSM states (IDLE / RUN / STOP)
//   - LEFT / RIGHT     : channel encoding used on word select and data_is_right
//   - bit_cnt_w()      : width of the per-frame bit counter (one L+R frame)
//   - word_idx_w()     : width of the bit index inside one channel word
// ---------------------------------------------------------------------------
package i2s_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // One frame is a left word followed by a right word.
  function automatic int bit_cnt_w(input int data_width);
    return $clog2(2 * data_width);
  endfunction

  function automatic int word_idx_w(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// ---------------------------------------------------------------------------
// i2s_clk_gen
// Divides clk_i down to the I2S serial clock. The counter runs 0..div_i and
// each wrap toggles SCK. rise_o / fall_o are single-cycle strobes asserted in
// the cycle whose closing clk_i edge drives SCK high / low, so logic clocked
// on that same edge sees the SCK transition as it happens.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous active-high reset
//   en_i    in   run the divider
//   clr_i   in   force counter and SCK to 0 (wins over en_i)
//   div_i   in   half-period minus one, in clk_i cycles
//   sck_o   out  serial clock
//   rise_o  out  SCK goes high on the next clk_i edge
//   fall_o  out  SCK goes low on the next clk_i edge
// ---------------------------------------------------------------------------
module i2s_clk_gen #(
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [CLK_DIV_WIDTH-1:0] div_i,
  output logic                     sck_o,
  output logic                     rise_o,
  output logic                     fall_o
);

  logic [CLK_DIV_WIDTH-1:0] cnt_q;
  logic                     sck_q;
  logic                     tick;

  assign tick   = en_i && !clr_i && (cnt_q == div_i);
  assign rise_o = tick && !sck_q;
  assign fall_o = tick &&  sck_q;
  assign sck_o  = sck_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (en_i) begin
      if (tick) begin
        cnt_q <= '0;
        sck_q <= ~sck_q;
      end else begin
        cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_rx_controller.sv
// ---------------------------------------------------------------------------
// i2s_rx_controller
// Master-mode I2S receiver: generates SCK/WS for an external microphone,
// deserialises SD (MSB first, standard I2S one-bit delay) and presents each
// captured word on a valid/ready interface.
//
// Build option: I2S_RX_CTRL_STEREO_EN
//   defined   -> left and right words are delivered
//   undefined -> right words are discarded, data_is_right_o tied to LEFT
//
// Ports:
//   clk_i, rst_i       system clock, synchronous active-high reset
//   en_i               run request (ignored while stopping)
//   clk_div_i          SCK half-period minus one, latched when leaving IDLE
//   i2s_sck_o          serial clock
//   i2s_ws_o           word select (0 = left, 1 = right)
//   i2s_sd_i           serial data
//   data_o             captured word
//   data_is_right_o    channel of data_o
//   data_valid_o       data_o holds an undelivered word
//   data_ready_i       consumer accepts data_o
//   overflow_o         sticky: a completed word was dropped
//   busy_o             controller not idle
// ---------------------------------------------------------------------------
module i2s_rx_controller
  import i2s_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div_i,
  output logic                     i2s_sck_o,
  output logic                     i2s_ws_o,
  input  logic                     i2s_sd_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     data_is_right_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     overflow_o,
  output logic                     busy_o
);

  localparam int BIT_CNT_W  = bit_cnt_w(DATA_WIDTH);
  localparam int WORD_IDX_W = word_idx_w(DATA_WIDTH);

  state_e                   state_q;
  logic [CLK_DIV_WIDTH-1:0] clk_div_q;
  logic [BIT_CNT_W-1:0]     bit_cnt_q;
  logic [DATA_WIDTH-2:0]    shift_q;
  logic [DATA_WIDTH-1:0]    shift_d;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     valid_q;
  logic                     ovf_q;
  logic                     busy_q;
  logic                     suppress_q;
`ifdef I2S_RX_CTRL_STEREO_EN
  logic                     right_q;
`endif

  logic rise;
  logic fall;
  logic word_done;
  logic word_chan;
  logic word_keep;

  i2s_clk_gen #(
    .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
  ) u_clk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_q == ST_IDLE),
    .div_i  (clk_div_q),
    .sck_o  (i2s_sck_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  // SD is launched by the microphone on the SCK fall and held a full
  // half-period before we sample it, so it is captured directly.
  assign shift_d = {shift_q, i2s_sd_i};

  // A word ends on the rise whose bit index wraps to 0. WS has already
  // switched to the next channel, so the finished word is the other one.
  assign word_done = rise && (bit_cnt_q[WORD_IDX_W-1:0] == '0);
  assign word_chan = (bit_cnt_q[BIT_CNT_W-1] == LEFT) ? RIGHT : LEFT;

`ifdef I2S_RX_CTRL_STEREO_EN
  assign word_keep       = word_done && !suppress_q;
  assign data_is_right_o = right_q;
`else
  assign word_keep       = word_done && !suppress_q && (word_chan == LEFT);
  assign data_is_right_o = LEFT;
`endif

  assign i2s_ws_o     = bit_cnt_q[BIT_CNT_W-1];
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      clk_div_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      suppress_q <= 1'b0;
`ifdef I2S_RX_CTRL_STEREO_EN
      right_q    <= LEFT;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          if (en_i) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            clk_div_q  <= clk_div_i;
            ovf_q      <= 1'b0;
            suppress_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en_i) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (word_done && (word_chan == RIGHT)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Divider strobes only occur outside IDLE, so these never collide
      // with the IDLE clear above.
      if (rise)      shift_q    <= shift_d[DATA_WIDTH-2:0];
      if (fall)      bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
      if (word_done) suppress_q <= 1'b0;

      // A same-cycle accept frees the holding register for the new word.
      if (word_keep) begin
        if (!valid_q || data_ready_i) begin
          data_q  <= shift_d;
          valid_q <= 1'b1;
`ifdef I2S_RX_CTRL_STEREO_EN
          right_q <= word_chan;
`endif
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && data_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_controller.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_controller
// Drives an I2S microphone model and scores delivered words against a
// frame-level model: word k of the stream finishes on SCK rise DW+1+DW*k,
// odd words are right, and a run dropped during word j ends after the first
// right word at or after j.
// ---------------------------------------------------------------------------
module tb_i2s_rx_controller;

  localparam int DW = 32;
  localparam int CW = 16;
`ifdef I2S_RX_CTRL_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic [CW-1:0] clk_div_i = '0;
  logic          i2s_sck_o;
  logic          i2s_ws_o;
  logic          i2s_sd_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          data_is_right_o;
  logic          data_valid_o;
  logic          data_ready_i = 1'b1;
  logic          overflow_o;
  logic          busy_o;

  typedef struct packed {
    logic          right;
    logic [DW-1:0] data;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] tx_words[16];
  int            n_vec = 0;
  int            n_miss = 0;

  i2s_rx_controller #(
    .DATA_WIDTH    (DW),
    .CLK_DIV_WIDTH (CW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .en_i            (en_i),
    .clk_div_i       (clk_div_i),
    .i2s_sck_o       (i2s_sck_o),
    .i2s_ws_o        (i2s_ws_o),
    .i2s_sd_i        (i2s_sd_i),
    .data_o          (data_o),
    .data_is_right_o (data_is_right_o),
    .data_valid_o    (data_valid_o),
    .data_ready_i    (data_ready_i),
    .overflow_o      (overflow_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream bit idx is the one sampled on SCK rise idx+2.
  function automatic logic tx_bit(input int idx);
    int k;
    k = idx / DW;
    if (idx < 0 || k >= 16) return 1'b0;
    return tx_words[k][DW-1-(idx % DW)];
  endfunction

  task automatic fill_fixed();
    for (int i = 0; i < 16; i++) tx_words[i] = (i % 2 == 1) ? 32'h0FEDCBA9 : 32'h08765431;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) tx_words[i] = $urandom;
  endtask

  // hold_until: ready low from start until this rise count (0 = ready high).
  // pulse: ready only in the cycle ending on a word-boundary rise (div 0).
  // rst_rise: assert reset at this rise count and check reset values.
  task automatic run(input int div, input int stop_rise, input int hold_until,
                     input bit pulse, input int rst_rise);
    int    rise_cnt, fall_cnt, cyc, rise2_cyc, budget, j, last, c;
    bit    prev_sck, got_first, exp_ovf, done;
    word_t w;
    rise_cnt = 0; fall_cnt = 0; cyc = 0; rise2_cyc = 0;
    prev_sck = 1'b0; got_first = 1'b0; exp_ovf = 1'b0; done = 1'b0;

    exp_q.delete();
    j    = (stop_rise - 1) / DW;
    last = (j % 2 == 1) ? j : j + 1;
    for (int k = 0; k <= last; k++) begin
      if (STEREO || (k % 2 == 0)) begin
        c = DW + 1 + DW * k;
        if (hold_until > 0 && c > DW + 1 && c < hold_until) exp_ovf = 1'b1;
        else exp_q.push_back('{right: (k % 2 == 1), data: tx_words[k]});
      end
    end

    budget       = (stop_rise + 2 * DW + 8) * 2 * (div + 1) + 20;
    data_ready_i = (hold_until == 0) && !pulse;
    clk_div_i    = CW'(div);
    i2s_sd_i     = 1'($urandom);
    en_i         = 1'b1;
    @(negedge clk_i);
    check("start_busy", busy_o, 1);
    check("start_ovf_clear", overflow_o, 0);
    clk_div_i = CW'(div + 2);

    while (!done && cyc < budget) begin
      if (i2s_sck_o && !prev_sck) begin
        rise_cnt++;
        if (rise_cnt == 2) rise2_cyc = cyc;
        if (rise_cnt == 3) check("sck_period", cyc - rise2_cyc, 2 * (div + 1));
      end
      if (!i2s_sck_o && prev_sck) begin
        fall_cnt++;
        i2s_sd_i = tx_bit(fall_cnt - 1);
      end
      prev_sck = i2s_sck_o;

      if (data_valid_o && !got_first) begin
        got_first = 1'b1;
        check("first_valid_rise", rise_cnt, DW + 1);
      end

      if (rst_rise > 0 && rise_cnt == rst_rise) begin
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_sck", i2s_sck_o, 0);
        check("rst_ws", i2s_ws_o, 0);
        check("rst_data", data_o, 0);
        check("rst_right", data_is_right_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        en_i = 1'b0;
        data_ready_i = 1'b1;
        done = 1'b1;
      end else begin
        if (hold_until > 0 && !data_ready_i && rise_cnt >= hold_until) begin
          check("ovf_while_held", overflow_o, exp_ovf);
          check("held_word", data_o, tx_words[0]);
          data_ready_i = 1'b1;
        end
        if (pulse)
          data_ready_i = (!i2s_sck_o && ((rise_cnt + 1) % DW == 1) && (rise_cnt + 1 > DW + 1))
                         || !busy_o;

        if (data_valid_o && data_ready_i) begin
          if (exp_q.size() == 0) begin
            check("extra_word_valid", data_valid_o, 0);
          end else begin
            w = exp_q.pop_front();
            check("word_data", data_o, w.data);
            check("word_chan", data_is_right_o, w.right);
          end
        end

        if (en_i && rise_cnt == stop_rise) en_i = 1'b0;
        if (!en_i && !busy_o) done = 1'b1;
      end

      if (!done) begin
        @(negedge clk_i);
        cyc++;
      end
    end

    check("run_completed", done, 1);
    if (rst_rise == 0) begin
      check("words_missing", exp_q.size(), 0);
      @(negedge clk_i);
      check("idle_sck", i2s_sck_o, 0);
      check("idle_ws", i2s_ws_o, 0);
      check("idle_busy", busy_o, 0);
      check("idle_valid", data_valid_o, 0);
      check("idle_ovf", overflow_o, exp_ovf);
    end
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_sck", i2s_sck_o, 0);
    check("reset_ws", i2s_ws_o, 0);
    check("reset_data", data_o, 0);
    check("reset_right", data_is_right_o, 0);
    check("reset_valid", data_valid_o, 0);
    check("reset_ovf", overflow_o, 0);
    check("reset_busy", busy_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reference pattern, div 3, en dropped mid-left word 4.
    fill_fixed();
    run(3, 140, 0, 1'b0, 0);

    // Fastest SCK.
    run(0, 75, 0, 1'b0, 0);

    // Ready held low across two word boundaries.
    fill_random();
    run($urandom_range(0, 3), 150, 110, 1'b0, 0);

    // Ready only on completion cycles; also clears the previous overflow.
    fill_random();
    run(0, 170, 0, 1'b1, 0);

    // Reset in the middle of a word while a word is held.
    fill_random();
    run($urandom_range(0, 2), 400, 1000, 1'b0, 50);

    // Recovery after reset.
    fill_random();
    run($urandom_range(0, 3), 100, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
